// File: rtl/vga_ball_renderer.sv
// vga_ball_renderer: pixel-content stage behind the VGA timing generator.
// It draws a square ball that bounces off the screen edges and moves once per
// frame. A debounced push button steps the ball colour through 1..7.
// Optional macro BOUNCE_COUNT_EN: adds an 8-bit wall-hit counter, shown as a
// white bar on lines 0..3.
module vga_ball_renderer #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BALL_SIZE       = 8,
    parameter int SPEED           = 4,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic        CLK_24M,
    input  logic        RST_N,
    input  logic [10:0] HCOUNT,
    input  logic [10:0] VCOUNT,
    input  logic        USR_BTN,
    output logic [2:0]  VGA_RGB,
    output logic        FRAME_TICK,
    output logic        BTN_LEVEL
);

    localparam int          CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} db_state_t;

    logic [10:0]   ball_x, ball_y;
    logic          dx_pos, dy_pos;
    logic [2:0]    colour;
    logic          tick_now;
    logic          x_flip, y_flip;
    logic          active, in_ball, bar_on;
    logic [1:0]    btn_sync;
    logic          btn_s;
    db_state_t     db_state;
    logic [CW-1:0] db_cnt;

    assign tick_now = (HCOUNT == 11'd0) && (VCOUNT == 11'(V_ACTIVE));
    assign btn_s    = btn_sync[1];

    // Wall-hit detection for the current direction of travel on each axis
    always_comb begin
        x_flip = dx_pos ? (({1'b0, ball_x} + 12'(SPEED)) >= {1'b0, X_MAX})
                        : (ball_x <= 11'(SPEED));
        y_flip = dy_pos ? (({1'b0, ball_y} + 12'(SPEED)) >= {1'b0, Y_MAX})
                        : (ball_y <= 11'(SPEED));
    end

    // Ball motion, applied only on the vertical-blanking tick
    always_ff @(posedge CLK_24M) begin
        if (!RST_N) begin
            ball_x     <= '0;
            ball_y     <= '0;
            dx_pos     <= 1'b1;
            dy_pos     <= 1'b1;
            FRAME_TICK <= 1'b0;
        end else begin
            FRAME_TICK <= tick_now;
            if (tick_now) begin
                if (dx_pos) ball_x <= x_flip ? X_MAX : ball_x + 11'(SPEED);
                else        ball_x <= x_flip ? '0    : ball_x - 11'(SPEED);
                if (dy_pos) ball_y <= y_flip ? Y_MAX : ball_y + 11'(SPEED);
                else        ball_y <= y_flip ? '0    : ball_y - 11'(SPEED);
                if (x_flip) dx_pos <= ~dx_pos;
                if (y_flip) dy_pos <= ~dy_pos;
            end
        end
    end

`ifdef BOUNCE_COUNT_EN
    logic [7:0] bounce_cnt;

    // Count ticks that hit at least one wall; a corner counts once
    always_ff @(posedge CLK_24M) begin
        if (!RST_N)                          bounce_cnt <= '0;
        else if (tick_now && (x_flip || y_flip)) bounce_cnt <= bounce_cnt + 8'd1;
    end

    // Each counter bit owns a 64-pixel span of the bar on lines 0..3
    always_comb begin
        bar_on = (VCOUNT < 11'd4) && (HCOUNT < 11'd512) && bounce_cnt[HCOUNT[8:6]];
    end
`else
    assign bar_on = 1'b0;
`endif

    // Hit test of the current beam position against the ball square
    always_comb begin
        active  = (HCOUNT < 11'(H_ACTIVE)) && (VCOUNT < 11'(V_ACTIVE));
        in_ball = ({1'b0, HCOUNT} >= {1'b0, ball_x}) &&
                  ({1'b0, HCOUNT} <  {1'b0, ball_x} + 12'(BALL_SIZE)) &&
                  ({1'b0, VCOUNT} >= {1'b0, ball_y}) &&
                  ({1'b0, VCOUNT} <  {1'b0, ball_y} + 12'(BALL_SIZE));
    end

    // Registered pixel output: ball over bar over black
    always_ff @(posedge CLK_24M) begin
        if (!RST_N)       VGA_RGB <= '0;
        else if (!active) VGA_RGB <= '0;
        else if (in_ball) VGA_RGB <= colour;
        else if (bar_on)  VGA_RGB <= 3'b111;
        else              VGA_RGB <= '0;
    end

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge CLK_24M) begin
        if (!RST_N) btn_sync <= '0;
        else        btn_sync <= {btn_sync[0], USR_BTN};
    end

    // Debounce FSM; entering PRESSED from WAIT_PRESS advances the colour
    always_ff @(posedge CLK_24M) begin
        if (!RST_N) begin
            db_state  <= IDLE;
            db_cnt    <= '0;
            BTN_LEVEL <= 1'b0;
            colour    <= 3'b001;
        end else begin
            case (db_state)
                IDLE: begin
                    if (btn_s) begin
                        db_state <= WAIT_PRESS;
                        db_cnt   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!btn_s) begin
                        db_state <= IDLE;
                    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_state  <= PRESSED;
                        BTN_LEVEL <= 1'b1;
                        colour    <= (colour == 3'd7) ? 3'd1 : colour + 3'd1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        db_state <= WAIT_RELEASE;
                        db_cnt   <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (btn_s) begin
                        db_state <= PRESSED;
                    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_state  <= IDLE;
                        BTN_LEVEL <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: db_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_ball_renderer.sv
// Self-checking bench for vga_ball_renderer: drives the H/V counters directly,
// keeps a behavioural model of ball position, colour and debounced button.
module tb_vga_ball_renderer;

    localparam int HA = 640, VA = 480, BS = 8, SP = 4, DB = 16;

    logic        CLK_24M = 1'b0;
    logic        RST_N   = 1'b0;
    logic [10:0] HCOUNT  = '0;
    logic [10:0] VCOUNT  = '0;
    logic        USR_BTN = 1'b0;
    logic [2:0]  VGA_RGB;
    logic        FRAME_TICK;
    logic        BTN_LEVEL;

    int checks = 0;
    int errors = 0;

    always #5 CLK_24M = ~CLK_24M;

    vga_ball_renderer #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .BALL_SIZE(BS), .SPEED(SP), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK_24M(CLK_24M), .RST_N(RST_N), .HCOUNT(HCOUNT), .VCOUNT(VCOUNT),
        .USR_BTN(USR_BTN), .VGA_RGB(VGA_RGB), .FRAME_TICK(FRAME_TICK), .BTN_LEVEL(BTN_LEVEL)
    );

    // model state
    int mx, my, mcol, mrun, mbounce, corner_hits;
    bit mdx, mdy, mlvl, d1, d2;

    function void model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mcol = 1;
        mlvl = 0; mrun = 0; d1 = 0; d2 = 0; mbounce = 0;
    endfunction

    // Move by SPEED and clamp into [0, MAX]; a clamp reverses direction
    function void model_tick();
        int nx, ny;
        bit fx, fy;
        nx = mx + (mdx ? SP : -SP);
        ny = my + (mdy ? SP : -SP);
        fx = 0; fy = 0;
        if (nx >= HA - BS) begin nx = HA - BS; fx = 1; end
        if (nx <= 0)       begin nx = 0;       fx = 1; end
        if (ny >= VA - BS) begin ny = VA - BS; fy = 1; end
        if (ny <= 0)       begin ny = 0;       fy = 1; end
        if (fx) mdx = !mdx;
        if (fy) mdy = !mdy;
        if (fx && fy) corner_hits++;
        if (fx || fy) mbounce = (mbounce + 1) % 256;
        mx = nx; my = ny;
    endfunction

    // Level follows the synchronised input once it has disagreed for DB+1 samples
    function void model_btn(bit b);
        bit s;
        s = d2; d2 = d1; d1 = b;
        if (s != mlvl) begin
            mrun++;
            if (mrun == DB + 1) begin
                mlvl = s; mrun = 0;
                if (s) mcol = (mcol == 7) ? 1 : mcol + 1;
            end
        end else begin
            mrun = 0;
        end
    endfunction

    function logic [2:0] exp_rgb(int h, int v);
        logic [7:0] bc;
        bc = 8'(mbounce);
        if (h >= HA || v >= VA) return 3'b000;
        if (h >= mx && h < mx + BS && v >= my && v < my + BS) return 3'(mcol);
`ifdef BOUNCE_COUNT_EN
        if (v < 4 && h < 512 && bc[h / 64]) return 3'b111;
`else
        if (bc == 8'hxx) return 3'b000;
`endif
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare every output
    task automatic step(input int h, input int v, input bit b);
        logic [2:0] er;
        bit         et;
        HCOUNT = 11'(h); VCOUNT = 11'(v); USR_BTN = b;
        er = exp_rgb(h, v);
        et = (h == 0 && v == VA);
        @(posedge CLK_24M); #1;
        if (et) model_tick();
        model_btn(b);
        chk($sformatf("rgb(%0d,%0d)", h, v), 32'(VGA_RGB), 32'(er));
        chk("frame_tick", 32'(FRAME_TICK), 32'(et));
        chk("btn_level", 32'(BTN_LEVEL), 32'(mlvl));
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        repeat (n) begin
            HCOUNT = 11'($urandom_range(799, 0));
            VCOUNT = 11'($urandom_range(524, 0));
            USR_BTN = 1'($urandom_range(1, 0));
            @(posedge CLK_24M); #1;
        end
        model_reset();
        RST_N = 1'b1;
        chk("rst_rgb", 32'(VGA_RGB), 32'd0);
        chk("rst_tick", 32'(FRAME_TICK), 32'd0);
        chk("rst_btn", 32'(BTN_LEVEL), 32'd0);
    endtask

    initial begin
        int rise_at;
        corner_hits = 0;
        model_reset();

        // reset state: ball at origin in colour 1
        do_reset(3);
        step(3, 2, 0);   chk("px_3_2", 32'(VGA_RGB), 32'd1);
        step(8, 2, 0);   chk("px_8_2", 32'(VGA_RGB), 32'd0);
        step(700, 2, 0); chk("px_700_2", 32'(VGA_RGB), 32'd0);
        step(0, 0, 0);
        step(7, 7, 0);
        step(0, 8, 0);
        step(650, 490, 0);

        // first tick moves to (4,4)
        step(0, VA, 0);  chk("tick_pulse", 32'(FRAME_TICK), 32'd1);
        step(4, 4, 0);   chk("px_4_4", 32'(VGA_RGB), 32'd1);
        step(3, 4, 0);   chk("px_3_4", 32'(VGA_RGB), 32'd0);
        step(11, 11, 0); chk("px_11_11", 32'(VGA_RGB), 32'd1);
        step(12, 4, 0);  chk("px_12_4", 32'(VGA_RGB), 32'd0);

        // long run covering every wall and a corner hit
        for (int t = 0; t < 9400; t++) begin
            step(0, VA, 0);
            step(mx, my, 0);
            step(mx + BS, my + BS - 1, 0);
            if (mx > 0) step(mx - 1, my, 0);
            if (my > 0) step(mx + BS - 1, my - 1, 0);
            if (t % 8 == 0) step(int'($urandom_range(799, 0)), int'($urandom_range(524, 0)), 0);
        end
        chk("corner_seen", 32'(corner_hits > 0), 32'd1);

        // fresh start for button tests
        do_reset(2);
        for (int i = 0; i < 5; i++) step(mx, my, 1);
        for (int i = 0; i < 40; i++) step(mx, my, 0);
        step(mx, my, 0); chk("glitch_colour", 32'(VGA_RGB), 32'd1);

        rise_at = -1;
        for (int i = 1; i <= 40; i++) begin
            step(mx, my, 1);
            if (rise_at < 0 && BTN_LEVEL === 1'b1) rise_at = i;
        end
        chk("rise_latency", 32'(rise_at), 32'd19);
        for (int i = 0; i < 40; i++) step(mx, my, 0);
        step(mx, my, 0); chk("press_colour", 32'(VGA_RGB), 32'd2);

        // six more presses wrap the colour 7 -> 1, with ticks interleaved
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 30; i++)
                if ($urandom_range(5, 0) == 0) step(0, VA, 1); else step(mx, my, 1);
            for (int i = 0; i < 30; i++)
                if ($urandom_range(5, 0) == 0) step(0, VA, 0); else step(mx, my, 0);
        end
        step(mx, my, 0); chk("wrap_colour", 32'(VGA_RGB), 32'd1);

        // random glitches and presses
        for (int p = 0; p < 12; p++) begin
            int hi, lo;
            hi = int'($urandom_range(40, 1));
            lo = int'($urandom_range(40, 1));
            for (int i = 0; i < hi; i++)
                if ($urandom_range(3, 0) == 0) step(0, VA, 1); else step(mx, my, 1);
            for (int i = 0; i < lo; i++)
                if ($urandom_range(3, 0) == 0) step(0, VA, 0); else step(mx, my, 0);
        end

        // reset mid-debounce and mid-motion: nothing persists
        for (int i = 0; i < 3; i++) step(0, VA, 0);
        for (int i = 0; i < 10; i++) step(mx, my, 1);
        do_reset(1);
        step(0, 0, 1);   chk("post_rst_origin", 32'(VGA_RGB), 32'd1);
        for (int i = 0; i < 25; i++) step(mx, my, 1);
        for (int i = 0; i < 25; i++) step(mx, my, 0);
        step(mx, my, 0); chk("post_rst_colour", 32'(VGA_RGB), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
